moore_pattern_detector: RTL and testbench
=========================================

# moore_pattern_detector

Parametrised Moore-type serial sequence detector. Successor to the fixed-pattern single-bit detector. Adds the following over that block:
- runtime-programmable pattern of length PAT_LEN;
- overlapping and non-overlapping match modes;
- input-valid qualification;
- a saturating match counter.

It sits on a serial bit stream in the lab datapath and flags each completed occurrence of the programmed pattern.

## Interface
- PAT_LEN, 4, pattern length in bits (≥2)
- CNT_W, 8, match counter width
- PAT_RESET, 4'b1011 (PAT_LEN bits), pattern loaded at reset
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- inbit  in  1  serial data bit
- in_valid  in  1  inbit is sampled only when high
- load  in  1  load pattern_in into the pattern register
- pattern_in  in  PAT_LEN  new pattern; MSB is the earliest bit in time
- overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping
- clear_count  in  1  synchronous clear of match_count
- ans  out  1  Moore output, high while FSM is in S_MATCH
- match_count  out  CNT_W  number of matches since reset/clear, saturating

## Operation
- **State held**
  - pattern register pat[PAT_LEN-1:0]
  - history shift register hist[PAT_LEN-1:0], newest bit in LSB
  - fill counter fill (0..PAT_LEN)
  - FSM state
- **States**
  - S_FILL: fill < PAT_LEN.
  - S_SCAN: history full, no match.
  - S_MATCH: the last accepted bit completed a match.
- **Accepted bit** (in_valid=1, load=0)
  - hist_n = {hist[PAT_LEN-2:0], inbit}
  - fill_n = min(fill+1, PAT_LEN)
- **Transitions** (evaluated on each accepted bit, from any state)
  - If fill_n==PAT_LEN and hist_n==pat: go to S_MATCH and increment match_count.
  - Otherwise, if fill_n==PAT_LEN: go to S_SCAN.
  - Otherwise: go to S_FILL.
- **Non-overlap mode** (overlap=0): entering S_MATCH also sets fill to 0. No bit of a completed match is reused.
- **Overlap mode** (overlap=1): fill stays at PAT_LEN, so the next accepted bit can complete a new match.
- **in_valid=0**: state, hist, fill, ans and match_count all hold. ans stays high in S_MATCH until the next accepted bit.
- **load=1**
  - pat ← pattern_in; hist ← 0; fill ← 0; state ← S_FILL.
  - match_count is unchanged.
  - load has priority: a bit presented in the same cycle is discarded.
- **clear_count=1**: match_count ← 0. Clear wins over a simultaneous increment.
- **Saturation**: match_count saturates at 2^CNT_W−1; further matches still drive ans.
- **overlap mode changes**: take effect on the next accepted bit. No flush occurs.

## Timing
- All inputs are sampled on the rising edge of clk.
- ans is a registered decode of state, with no combinational path from inbit.
- Latency: ans rises on the clock edge that accepts the final matching bit and is visible for the following cycle(s).
- match_count updates on the same edge as the ans rise.
- **Reset** (rst_n=0, asynchronous, mid-operation included):
  - state=S_FILL, hist=0, fill=0, pat=PAT_RESET;
  - ans=0, match_count=0.
- **Reset release**: the first edge with rst_n=1 may accept a bit.
- **Back-to-back matches** in overlap mode hold ans high continuously across the matching bits.

## Structure
- Shared package `moore_pattern_pkg`:
  - state encoding localparams S_FILL=2'd0, S_SCAN=2'd1, S_MATCH=2'd2;
  - a function computing the counter maximum from CNT_W.
- One sub-module: `sat_counter` (parameter CNT_W; inputs inc and clr with clr priority; saturating output).
- The FSM, history register and pattern register live in the top module.

## Test plan
All scenarios use PAT_LEN=4 and pat=1011 unless stated otherwise.

1. **Reset defaults.** Assert rst_n=0 at an arbitrary time.
   - Required: ans=0, match_count=0 immediately (asynchronously).
   - Required: with no load, pattern 1011 is detected after release.
2. **Overlap mode.** overlap=1, stream 1,0,1,1,0,1,1 with in_valid=1 every cycle.
   - Required: ans high after bit 4 and again after bit 7.
   - Required: match_count=2.
3. **Non-overlap mode.** overlap=0, same stream as scenario 2.
   - Required: ans high only after bit 4.
   - Required: match_count=1; the FSM returns to S_FILL with fill=1 after bit 5.
4. **in_valid gaps.** Stream 1,0,1,1 with in_valid=0 for 3 cycles between each bit.
   - Required: a single match; ans stays high through the in_valid=0 cycles after bit 4.
   - Required: ans falls on the next accepted bit.
5. **Load and count.**
   - load=1 with pattern_in=0000 and in_valid=1 in the same cycle: the bit is discarded, match_count is retained, and ans rises only after 4 further accepted zeros.
   - clear_count asserted together with a matching bit: match_count=0 and ans=1.
6. **Saturation.** CNT_W=2, overlap=1, a stream producing 5 matches.
   - Required: match_count=3 after the 3rd and every later match.
   - Required: ans still pulses on every match.

Source files
------------

// File: rtl/moore_pattern_pkg.sv
// Shared definitions for the programmable Moore pattern detector:
// state encoding and the saturating counter ceiling.
package moore_pattern_pkg;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_SCAN  = 2'd1,
    S_MATCH = 2'd2
  } state_t;

  // Largest value representable in a w-bit counter (w clamped at 32).
  function automatic logic [31:0] cnt_max(input int unsigned w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/moore_pattern_detector_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter
  import moore_pattern_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/moore_pattern_detector.sv
// Serial detector for a runtime-programmable PAT_LEN-bit pattern with
// overlap control, input qualification and a saturating match counter.
module moore_pattern_detector
  import moore_pattern_pkg::*;
#(
  parameter int                 PAT_LEN   = 4,
  parameter int                 CNT_W     = 8,
  parameter logic [PAT_LEN-1:0] PAT_RESET = 4'b1011
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               inbit,
  input  logic                               in_valid,
  input  logic                               load,
  input  logic [PAT_LEN-1:0]                 pattern_in,
  input  logic                               overlap,
  input  logic                               clear_count,
  output logic                               ans,
  output logic [CNT_W-1:0]                   match_count,
  output logic [1:0]                         dbg_state,
  output logic [$clog2(PAT_LEN+1)-1:0]       dbg_fill
);

  localparam int              FW   = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]   FULL = FW'(PAT_LEN);

  // Handshake: a bit is accepted on a rising edge where in_valid=1 and
  // load=0; there is no backpressure, and ans/match_count are valid
  // every cycle after the edge that changed them.

  state_t               state, state_n;
  logic [PAT_LEN-1:0]   pat, pat_n;
  logic [PAT_LEN-1:0]   hist, hist_n, hist_shift;
  logic [FW-1:0]        fill, fill_n, fill_inc;
  logic                 hit;
  logic                 inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FILL;
      pat   <= PAT_RESET;
      hist  <= '0;
      fill  <= '0;
    end else begin
      state <= state_n;
      pat   <= pat_n;
      hist  <= hist_n;
      fill  <= fill_n;
    end
  end

  always_comb begin
    hist_shift = {hist[PAT_LEN-2:0], inbit};
    fill_inc   = (fill == FULL) ? FULL : fill + 1'b1;
    hit        = (fill_inc == FULL) && (hist_shift == pat);

    state_n = state;
    pat_n   = pat;
    hist_n  = hist;
    fill_n  = fill;
    inc     = 1'b0;

    if (load) begin
      // Reprogramming flushes the history; any same-cycle bit is dropped.
      pat_n   = pattern_in;
      hist_n  = '0;
      fill_n  = '0;
      state_n = S_FILL;
    end else if (in_valid) begin
      hist_n = hist_shift;
      if (hit) begin
        state_n = S_MATCH;
        inc     = 1'b1;
        fill_n  = overlap ? FULL : '0;
      end else if (fill_inc == FULL) begin
        state_n = S_SCAN;
        fill_n  = fill_inc;
      end else begin
        state_n = S_FILL;
        fill_n  = fill_inc;
      end
    end
  end

  assign ans       = (state == S_MATCH);
  assign dbg_state = state;
  assign dbg_fill  = fill;

  sat_counter #(.CNT_W(CNT_W)) u_count (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc),
    .clr   (clear_count),
    .count (match_count)
  );

endmodule

// File: tb/tb_moore_pattern_detector.sv
// Directed bench: two detector instances (8-bit and 2-bit counters) share
// stimulus; expected responses are queued and checked by a monitor.
module tb_moore_pattern_detector;
  import moore_pattern_pkg::*;

  localparam int W = 17;
  localparam logic [1:0] F = S_FILL;
  localparam logic [1:0] S = S_SCAN;
  localparam logic [1:0] M = S_MATCH;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inbit = 1'b0;
  logic       in_valid = 1'b0;
  logic       load = 1'b0;
  logic [3:0] pattern_in = 4'b0000;
  logic       overlap = 1'b1;
  logic       clear_count = 1'b0;

  logic       ans, sat_ans;
  logic [7:0] match_count;
  logic [1:0] sat_count;
  logic [1:0] dbg_state, sat_state;
  logic [2:0] dbg_fill, sat_fill;

  logic [W-1:0] exp_q[$];
  string        nm_q[$];
  int           n_cmp = 0;
  int           n_fail = 0;

  moore_pattern_detector #(.PAT_LEN(4), .CNT_W(8), .PAT_RESET(4'b1011)) dut (
    .clk(clk), .rst_n(rst_n), .inbit(inbit), .in_valid(in_valid), .load(load),
    .pattern_in(pattern_in), .overlap(overlap), .clear_count(clear_count),
    .ans(ans), .match_count(match_count), .dbg_state(dbg_state), .dbg_fill(dbg_fill)
  );

  moore_pattern_detector #(.PAT_LEN(4), .CNT_W(2), .PAT_RESET(4'b1011)) dut_sat (
    .clk(clk), .rst_n(rst_n), .inbit(inbit), .in_valid(in_valid), .load(load),
    .pattern_in(pattern_in), .overlap(overlap), .clear_count(clear_count),
    .ans(sat_ans), .match_count(sat_count), .dbg_state(sat_state), .dbg_fill(sat_fill)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] pack(logic a, logic [7:0] c, logic [1:0] sc,
                                        logic [1:0] st, logic [2:0] fl);
    return {a, a, c, sc, st, fl};
  endfunction

  function automatic logic [W-1:0] actual();
    return {ans, sat_ans, match_count, sat_count, dbg_state, dbg_fill};
  endfunction

  task automatic check(string nm, logic [W-1:0] act, logic [W-1:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got ans=%b/%b cnt=%0d scnt=%0d st=%0d fill=%0d, expected ans=%b/%b cnt=%0d scnt=%0d st=%0d fill=%0d",
               nm, act[16], act[15], act[14:7], act[6:5], act[4:3], act[2:0],
               exp_v[16], exp_v[15], exp_v[14:7], exp_v[6:5], exp_v[4:3], exp_v[2:0]);
    end
  endtask

  // Driver: apply one cycle of inputs and queue the expected response.
  task automatic step(string nm, logic b, logic v, logic ld, logic [3:0] p, logic clr,
                      logic e_ans, logic [7:0] e_cnt, logic [1:0] e_scnt,
                      logic [1:0] e_st, logic [2:0] e_fl);
    inbit       = b;
    in_valid    = v;
    load        = ld;
    pattern_in  = p;
    clear_count = clr;
    @(posedge clk);
    #1;
    exp_q.push_back(pack(e_ans, e_cnt, e_scnt, e_st, e_fl));
    nm_q.push_back(nm);
  endtask

  task automatic bit_in(string nm, logic b, logic e_ans, logic [7:0] e_cnt,
                        logic [1:0] e_scnt, logic [1:0] e_st, logic [2:0] e_fl);
    step(nm, b, 1'b1, 1'b0, 4'b0000, 1'b0, e_ans, e_cnt, e_scnt, e_st, e_fl);
  endtask

  task automatic idle(string nm, logic e_ans, logic [7:0] e_cnt,
                      logic [1:0] e_scnt, logic [1:0] e_st, logic [2:0] e_fl);
    step(nm, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 4'b0000, 1'b0,
         e_ans, e_cnt, e_scnt, e_st, e_fl);
  endtask

  // Asynchronous reset mid-operation, checked before any clock edge.
  task automatic do_reset(string nm);
    @(negedge clk);
    #1;
    in_valid = 1'b0; load = 1'b0; clear_count = 1'b0;
    rst_n = 1'b0;
    #1;
    check(nm, actual(), pack(1'b0, 8'd0, 2'd0, F, 3'd0));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      string        n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      check(n, actual(), e);
    end
  end

  initial begin
    logic [15:0] seq;
    int          k;

    // Power-on reset
    repeat (2) @(negedge clk);
    check("por", actual(), pack(1'b0, 8'd0, 2'd0, F, 3'd0));
    #1 rst_n = 1'b1;

    // Overlap mode with the reset pattern 1011
    overlap = 1'b1;
    bit_in("ov_b1", 1, 0, 0, 0, F, 1);
    bit_in("ov_b2", 0, 0, 0, 0, F, 2);
    bit_in("ov_b3", 1, 0, 0, 0, F, 3);
    bit_in("ov_b4", 1, 1, 1, 1, M, 4);
    bit_in("ov_b5", 0, 0, 1, 1, S, 4);
    bit_in("ov_b6", 1, 0, 1, 1, S, 4);
    bit_in("ov_b7", 1, 1, 2, 2, M, 4);
    do_reset("rst_in_match");

    // Non-overlap mode
    overlap = 1'b0;
    bit_in("nov_b1", 1, 0, 0, 0, F, 1);
    bit_in("nov_b2", 0, 0, 0, 0, F, 2);
    bit_in("nov_b3", 1, 0, 0, 0, F, 3);
    bit_in("nov_b4", 1, 1, 1, 1, M, 0);
    bit_in("nov_b5", 0, 0, 1, 1, F, 1);
    bit_in("nov_b6", 1, 0, 1, 1, F, 2);
    bit_in("nov_b7", 1, 0, 1, 1, F, 3);
    do_reset("rst_nov");

    // in_valid gaps
    overlap = 1'b1;
    bit_in("gap_b1", 1, 0, 0, 0, F, 1);
    repeat (3) idle("gap_hold1", 0, 0, 0, F, 1);
    bit_in("gap_b2", 0, 0, 0, 0, F, 2);
    repeat (3) idle("gap_hold2", 0, 0, 0, F, 2);
    bit_in("gap_b3", 1, 0, 0, 0, F, 3);
    repeat (3) idle("gap_hold3", 0, 0, 0, F, 3);
    bit_in("gap_b4", 1, 1, 1, 1, M, 4);
    repeat (3) idle("gap_ans_hold", 1, 1, 1, M, 4);
    bit_in("gap_ans_fall", 0, 0, 1, 1, S, 4);

    // Load discards the same-cycle bit and keeps the count
    step("load_0000", 1, 1, 1, 4'b0000, 0, 0, 1, 1, F, 0);
    bit_in("z_b1", 0, 0, 1, 1, F, 1);
    bit_in("z_b2", 0, 0, 1, 1, F, 2);
    bit_in("z_b3", 0, 0, 1, 1, F, 3);
    bit_in("z_b4", 0, 1, 2, 2, M, 4);
    step("clr_with_match", 0, 1, 0, 4'b0000, 1, 1, 0, 0, M, 4);
    step("load_1011", 0, 0, 1, 4'b1011, 0, 0, 0, 0, F, 0);

    // Saturation: five overlapping matches of 1011
    seq = 16'b1011_0110_1101_1011;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 3) begin
        bit_in("sat_fill", seq[15-i], 0, 8'(k), 2'(k), F, 3'(i + 1));
      end else if (i % 3 == 0) begin
        k++;
        bit_in("sat_match", seq[15-i], 1, 8'(k), (k > 3) ? 2'd3 : 2'(k), M, 4);
      end else begin
        bit_in("sat_scan", seq[15-i], 0, 8'(k), (k > 3) ? 2'd3 : 2'(k), S, 4);
      end
    end

    // Back-to-back overlapping matches keep ans high
    step("load_1111", 0, 0, 1, 4'b1111, 0, 0, 5, 3, F, 0);
    bit_in("b2b_f1", 1, 0, 5, 3, F, 1);
    bit_in("b2b_f2", 1, 0, 5, 3, F, 2);
    bit_in("b2b_f3", 1, 0, 5, 3, F, 3);
    bit_in("b2b_m1", 1, 1, 6, 3, M, 4);
    bit_in("b2b_m2", 1, 1, 7, 3, M, 4);
    bit_in("b2b_m3", 1, 1, 8, 3, M, 4);
    in_valid = 1'b0;

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
